// File: rtl/uart_msg_arbiter_pkg.sv
// Shared definitions for the UART message arbiter: FSM state encoding and the
// terminator byte appended after a message when enabled.
package uart_msg_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_TERM    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [7:0] TERM_BYTE = 8'h00;

    // States in which a byte is offered to the transmitter.
    function automatic logic is_tx_state(input state_e s);
        return (s == ST_SEND) || (s == ST_TERM);
    endfunction

endpackage

// File: rtl/uart_msg_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module rr_arbiter
    import uart_msg_arbiter_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found_s;
    logic hit_s;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s + 0;
        end
        return IDX_W'(s);
    endfunction

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            hit_s   = en && !found_s && req[wrap_add(ptr, k)];
            idx     = hit_s ? wrap_add(ptr, k) : idx;
            found_s = found_s | hit_s;
        end
        gnt = found_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/uart_msg_arbiter.sv
// Shares one uarttx between NUM_REQ message sources: round-robin grant, latch the
// owner's packed message and stream it MSB-first over the data/send/ready handshake.
module uart_msg_arbiter
    import uart_msg_arbiter_pkg::*;
#(
    parameter int  NUM_REQ      = 2,
    parameter int  MSG_BYTES    = 32,
    parameter int  BUSY_TIMEOUT = 4,
    localparam int LEN_W        = $clog2(MSG_BYTES + 1)
) (
    input  logic                           CLK,
    input  logic                           nrst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*MSG_BYTES*8-1:0] msg_in,
    input  logic [NUM_REQ*LEN_W-1:0]       msg_len,
    input  logic                           term_en,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [7:0]                     tx_data,
    output logic                           tx_send,
    input  logic                           tx_ready
);

    localparam int MSG_W = MSG_BYTES * 8;
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               term_en_q, term_en_d;
    logic               term_sent_q, term_sent_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic               tx_send_q, tx_send_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [IDX_W-1:0]   arb_idx_s;
    logic [LEN_W-1:0]   len_sel_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req (req),
        .ptr (ptr_q),
        .en  (state_q == ST_IDLE),
        .gnt (arb_gnt_s),
        .idx (arb_idx_s)
    );

    assign len_sel_s = msg_len[owner_q*LEN_W +: LEN_W];

    // Next-state logic; outputs are derived from the next state so they leave flops.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        msg_d       = msg_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        term_en_d   = term_en_q;
        term_sent_d = term_sent_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_gnt_s) begin
                    state_d = ST_LOAD;
                    owner_d = arb_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                msg_d       = msg_in[owner_q*MSG_W +: MSG_W];
                term_en_d   = term_en;
                term_sent_d = 1'b0;
                if (len_sel_s > LEN_W'(MSG_BYTES)) begin
                    idx_d = LEN_W'(MSG_BYTES);
                end else begin
                    idx_d = len_sel_s;
                end
                if (idx_d != '0) begin
                    state_d = ST_SEND;
                end else if (term_en) begin
                    state_d = ST_TERM;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    idx_d   = idx_q - LEN_W'(1);
                    tmo_d   = '0;
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_SEND;
                end
            end
            // A transmitter that never shows busy still releases us after the timeout.
            ST_WAIT_LO: begin
                if (!tx_ready || (tmo_q == TMO_W'(BUSY_TIMEOUT - 1))) begin
                    state_d = ST_WAIT_HI;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_WAIT_HI: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_HI;
                end else if (idx_q != '0) begin
                    state_d = ST_SEND;
                end else if (term_en_q && !term_sent_q) begin
                    state_d = ST_TERM;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_TERM: begin
                if (tx_ready) begin
                    term_sent_d = 1'b1;
                    tmo_d       = '0;
                    state_d     = ST_WAIT_LO;
                end else begin
                    state_d = ST_TERM;
                end
            end
            ST_DONE: begin
                ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        grant_d   = busy_d ? (NUM_REQ'(1) << owner_d) : '0;
        done_d    = (state_d == ST_DONE) ? (NUM_REQ'(1) << owner_d) : '0;
        tx_send_d = is_tx_state(state_d);
        tx_data_d = (state_d == ST_SEND) ? 8'(msg_d >> {idx_d - LEN_W'(1), 3'b000}) : TERM_BYTE;
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            msg_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            term_en_q   <= 1'b0;
            term_sent_q <= 1'b0;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            tx_send_q   <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            msg_q       <= msg_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            term_en_q   <= term_en_d;
            term_sent_q <= term_sent_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            tx_send_q   <= tx_send_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign tx_send = tx_send_q;
    assign tx_data = tx_data_q;

endmodule
